// File: rtl/inv_shift_row_stream_pkg.sv
// Shared AES state helpers: byte-index geometry and the ShiftRows source-index tables.
package inv_shift_row_stream_pkg;

    localparam int unsigned AES_NB          = 4;
    localparam int unsigned AES_STATE_BYTES = 16;

    typedef logic [3:0] stateIdx_t;
    typedef logic [1:0] rowCol_t;

    // Entry k is the input byte index feeding output byte k, with k = 4*c + r.
    localparam stateIdx_t INV_SHIFT_SRC [AES_STATE_BYTES] = '{
        4'd0, 4'd13, 4'd10, 4'd7, 4'd4, 4'd1, 4'd14, 4'd11,
        4'd8, 4'd5,  4'd2,  4'd15, 4'd12, 4'd9, 4'd6, 4'd3
    };

    localparam stateIdx_t FWD_SHIFT_SRC [AES_STATE_BYTES] = '{
        4'd0, 4'd5, 4'd10, 4'd15, 4'd4, 4'd9, 4'd14, 4'd3,
        4'd8, 4'd13, 4'd2, 4'd7,  4'd12, 4'd1, 4'd6, 4'd11
    };

    function automatic rowCol_t idxCol(input stateIdx_t k);
        return k[3:2];
    endfunction

    function automatic rowCol_t idxRow(input stateIdx_t k);
        return k[1:0];
    endfunction

    function automatic stateIdx_t colRowIdx(input rowCol_t c, input rowCol_t r);
        return {c, r};
    endfunction

endpackage

// File: rtl/inv_shift_row_stream_shift_row_index.sv
// Combinational output-position to source-position map for (Inv)ShiftRows.
module shift_row_index
    import inv_shift_row_stream_pkg::*;
#(
    parameter bit INVERSE = 1'b1
) (
    input  logic [3:0] idx,
    output logic [3:0] src
);

    always_comb begin
        src = INVERSE ? INV_SHIFT_SRC[idx] : FWD_SHIFT_SRC[idx];
    end

endmodule

// File: rtl/inv_shift_row_stream.sv
// Byte-serial AES (Inv)ShiftRows with a two-bank ping-pong store between two valid/ready streams.
module inv_shift_row_stream
    import inv_shift_row_stream_pkg::*;
#(
    parameter bit INVERSE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       frame_err
);

    logic [7:0] bankMem [2][AES_STATE_BYTES];
    logic       wrBank;
    logic [3:0] wrCnt;
    logic       rdBank;
    logic [3:0] rdCnt;
    logic [1:0] full;
    logic [1:0] setFull;
    logic [1:0] clrFull;
    logic       frameErrQ;
    logic [3:0] srcIdx;
    logic       inAccept;
    logic       outAccept;
    logic       framingBad;
    logic       blockDone;

    shift_row_index #(.INVERSE(INVERSE)) srcMap (
        .idx (rdCnt),
        .src (srcIdx)
    );

    assign in_ready  = !full[wrBank];
    assign out_valid = full[rdBank];
    assign out_data  = bankMem[rdBank][srcIdx];
    assign out_last  = out_valid && (rdCnt == 4'd15);
    assign frame_err = frameErrQ;

    always_comb begin
        inAccept   = in_valid && in_ready;
        outAccept  = out_valid && out_ready;
        framingBad = inAccept && (in_last != (wrCnt == 4'd15));
        blockDone  = inAccept && !framingBad && in_last;
        setFull    = '0;
        clrFull    = '0;
        if (blockDone) begin
            setFull[wrBank] = 1'b1;
        end
        if (outAccept && (rdCnt == 4'd15)) begin
            clrFull[rdBank] = 1'b1;
        end
    end

    // Bytes of a bad frame still land in the non-full bank; resetting wrCnt discards them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrBank    <= 1'b0;
            wrCnt     <= '0;
            frameErrQ <= 1'b0;
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned k = 0; k < AES_STATE_BYTES; k++) begin
                    bankMem[b[0]][k[3:0]] <= '0;
                end
            end
        end else begin
            frameErrQ <= framingBad;
            if (inAccept) begin
                bankMem[wrBank][wrCnt] <= in_data;
                if (framingBad || blockDone) begin
                    wrCnt <= '0;
                end else begin
                    wrCnt <= wrCnt + 4'd1;
                end
                if (blockDone) begin
                    wrBank <= !wrBank;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdBank <= 1'b0;
            rdCnt  <= '0;
        end else if (outAccept) begin
            rdCnt <= rdCnt + 4'd1;
            if (rdCnt == 4'd15) begin
                rdBank <= !rdBank;
            end
        end
    end

    // Set and clear always name different banks, so both apply in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= '0;
        end else begin
            full <= (full | setFull) & ~clrFull;
        end
    end

endmodule

// File: tb/tb_inv_shift_row_stream.sv
// Directed self-checking bench for inv_shift_row_stream, plus a forward->inverse loopback pair.
module tb_inv_shift_row_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] inData;
    logic       inValid;
    logic       inLast;
    logic       inReady;
    logic [7:0] outData;
    logic       outValid;
    logic       outLast;
    logic       outReady;
    logic       frameErr;

    logic [7:0] lbInData;
    logic       lbInValid;
    logic       lbInLast;
    logic       lbInReady;
    logic [7:0] midData;
    logic       midValid;
    logic       midLast;
    logic       midReady;
    logic [7:0] lbOutData;
    logic       lbOutValid;
    logic       lbOutLast;
    logic       lbFrameErrA;
    logic       lbFrameErrB;

    int total = 0;
    int bad   = 0;

    int invPerm [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};
    logic [7:0] fips [16] = '{8'h19, 8'h3d, 8'he3, 8'hbe, 8'ha0, 8'hf4, 8'he2, 8'h2b,
                              8'h9a, 8'hc6, 8'h8d, 8'h2a, 8'he9, 8'hf8, 8'h48, 8'h08};

    logic [7:0] srcQ [$];
    logic       lastQ [$];
    logic [7:0] gotQ [$];
    logic       gotLastQ [$];
    int         lastAcceptCyc;
    int         firstOutCyc;
    int         stallBad;
    int         stallCnt;
    int         fErrCnt;
    bit         timedOut;

    always #5 clk = ~clk;

    inv_shift_row_stream #(.INVERSE(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (inData),
        .in_valid  (inValid),
        .in_last   (inLast),
        .in_ready  (inReady),
        .out_data  (outData),
        .out_valid (outValid),
        .out_last  (outLast),
        .out_ready (outReady),
        .frame_err (frameErr)
    );

    inv_shift_row_stream #(.INVERSE(1'b0)) fwdDut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (lbInData),
        .in_valid  (lbInValid),
        .in_last   (lbInLast),
        .in_ready  (lbInReady),
        .out_data  (midData),
        .out_valid (midValid),
        .out_last  (midLast),
        .out_ready (midReady),
        .frame_err (lbFrameErrA)
    );

    inv_shift_row_stream #(.INVERSE(1'b1)) invDut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (midData),
        .in_valid  (midValid),
        .in_last   (midLast),
        .in_ready  (midReady),
        .out_data  (lbOutData),
        .out_valid (lbOutValid),
        .out_last  (lbOutLast),
        .out_ready (1'b1),
        .frame_err (lbFrameErrB)
    );

    task automatic load_block(input logic [7:0] base);
        for (int k = 0; k < 16; k++) begin
            srcQ.push_back(base + 8'(k));
            lastQ.push_back(k == 15);
        end
    endtask

    // readyMode: 0 = out_ready held high, 1 = random, 2 = held low.
    task automatic drive_collect(input int nIn, input int readyMode, input int expectOut, input int maxCyc);
        int         sent;
        logic       prevStall;
        logic [7:0] prevData;
        logic       prevLast;
        sent = 0;
        prevStall = 1'b0;
        prevData = '0;
        prevLast = 1'b0;
        gotQ.delete();
        gotLastQ.delete();
        lastAcceptCyc = -1;
        firstOutCyc = -1;
        stallBad = 0;
        stallCnt = 0;
        fErrCnt = 0;
        timedOut = 1'b1;
        for (int cyc = 0; cyc < maxCyc; cyc++) begin
            @(negedge clk);
            if (sent == nIn && gotQ.size() >= expectOut) begin
                inValid = 1'b0;
                inLast = 1'b0;
                timedOut = 1'b0;
                break;
            end
            if (readyMode == 0) outReady = 1'b1;
            else if (readyMode == 1) outReady = 1'($urandom_range(0, 1));
            else outReady = 1'b0;
            if (prevStall && (outData !== prevData || outLast !== prevLast)) stallBad++;
            prevStall = outValid && !outReady;
            if (prevStall) stallCnt++;
            prevData = outData;
            prevLast = outLast;
            if (frameErr) fErrCnt++;
            if (outValid && outReady) begin
                if (firstOutCyc < 0) firstOutCyc = cyc;
                gotQ.push_back(outData);
                gotLastQ.push_back(outLast);
            end
            if (sent < nIn) begin
                inValid = 1'b1;
                inData = srcQ[sent];
                inLast = lastQ[sent];
                if (inReady) begin
                    if (sent == nIn - 1) lastAcceptCyc = cyc;
                    sent++;
                end
            end else begin
                inValid = 1'b0;
                inLast = 1'b0;
            end
        end
        inValid = 1'b0;
        inLast = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        inValid = 1'b0;
        inLast = 1'b0;
        inData = '0;
        outReady = 1'b0;
        lbInValid = 1'b0;
        lbInLast = 1'b0;
        lbInData = '0;
        #12;
        total++; if (inReady !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", inReady); end
        total++; if (outValid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", outValid); end
        total++; if (outData !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%02h want=00", outData); end
        total++; if (outLast !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%0b want=0", outLast); end
        total++; if (frameErr !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%0b want=0", frameErr); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [7:0] exp;
        int lastErr;
        srcQ.delete();
        lastQ.delete();
        load_block(8'h00);
        drive_collect(16, 0, 16, 80);
        total++; if (timedOut || gotQ.size() != 16) begin bad++; $display("FAIL basic_count got=%0d want=16", gotQ.size()); end
        lastErr = 0;
        for (int j = 0; j < 16 && j < gotQ.size(); j++) begin
            exp = 8'(invPerm[j]);
            total++; if (gotQ[j] !== exp) begin bad++; $display("FAIL basic_byte%0d got=%02h want=%02h", j, gotQ[j], exp); end
            if (gotLastQ[j] !== (j == 15)) lastErr++;
        end
        total++; if (lastErr != 0) begin bad++; $display("FAIL basic_out_last got=%0d_wrong want=0_wrong", lastErr); end
        total++; if (firstOutCyc !== lastAcceptCyc + 1) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", firstOutCyc, lastAcceptCyc + 1); end
        @(negedge clk);
        total++; if (outValid !== 1'b0) begin bad++; $display("FAIL basic_drained got=%0b want=0", outValid); end
    endtask

    task automatic test_loopback;
        int sent;
        int lastErr;
        logic [7:0] got [$];
        sent = 0;
        lastErr = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            if (sent == 16 && got.size() == 16) break;
            if (lbOutValid) begin
                got.push_back(lbOutData);
                if (lbOutLast !== (got.size() == 16)) lastErr++;
            end
            if (sent < 16) begin
                lbInValid = 1'b1;
                lbInData = fips[sent];
                lbInLast = (sent == 15);
                if (lbInReady) sent++;
            end else begin
                lbInValid = 1'b0;
                lbInLast = 1'b0;
            end
        end
        lbInValid = 1'b0;
        lbInLast = 1'b0;
        total++; if (got.size() != 16) begin bad++; $display("FAIL loop_count got=%0d want=16", got.size()); end
        for (int j = 0; j < 16 && j < got.size(); j++) begin
            total++; if (got[j] !== fips[j]) begin bad++; $display("FAIL loop_byte%0d got=%02h want=%02h", j, got[j], fips[j]); end
        end
        total++; if (lastErr != 0) begin bad++; $display("FAIL loop_out_last got=%0d_wrong want=0_wrong", lastErr); end
    endtask

    task automatic test_back_to_back;
        int sent;
        int lowCnt;
        int readCyc;
        logic inReadyAt;
        logic inReadyAfter;
        logic [7:0] exp;
        int lastErr;
        srcQ.delete();
        lastQ.delete();
        load_block(8'h40);
        load_block(8'h50);
        load_block(8'h60);
        gotQ.delete();
        gotLastQ.delete();
        sent = 0;
        lowCnt = 0;
        outReady = 1'b0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            if (lowCnt >= 4) break;
            inValid = 1'b1;
            inData = srcQ[sent];
            inLast = lastQ[sent];
            if (inReady) begin
                sent++;
                lowCnt = 0;
            end else begin
                lowCnt++;
            end
        end
        total++; if (sent != 32) begin bad++; $display("FAIL b2b_accepted got=%0d want=32", sent); end
        total++; if (inReady !== 1'b0) begin bad++; $display("FAIL b2b_in_ready_low got=%0b want=0", inReady); end
        readCyc = -1;
        inReadyAt = 1'b1;
        inReadyAfter = 1'b0;
        for (int cyc = 0; cyc < 150; cyc++) begin
            @(negedge clk);
            if (sent == 48 && gotQ.size() == 48) break;
            outReady = 1'b1;
            if (readCyc >= 0 && cyc == readCyc + 1) inReadyAfter = inReady;
            if (outValid) begin
                gotQ.push_back(outData);
                gotLastQ.push_back(outLast);
                if (gotQ.size() == 16) begin
                    readCyc = cyc;
                    inReadyAt = inReady;
                end
            end
            if (sent < 48) begin
                inValid = 1'b1;
                inData = srcQ[sent];
                inLast = lastQ[sent];
                if (inReady) sent++;
            end else begin
                inValid = 1'b0;
                inLast = 1'b0;
            end
        end
        inValid = 1'b0;
        inLast = 1'b0;
        total++; if (inReadyAt !== 1'b0) begin bad++; $display("FAIL b2b_ready_at_read got=%0b want=0", inReadyAt); end
        total++; if (inReadyAfter !== 1'b1) begin bad++; $display("FAIL b2b_ready_rise got=%0b want=1", inReadyAfter); end
        total++; if (gotQ.size() != 48) begin bad++; $display("FAIL b2b_count got=%0d want=48", gotQ.size()); end
        lastErr = 0;
        for (int j = 0; j < 48 && j < gotQ.size(); j++) begin
            exp = srcQ[(j / 16) * 16 + invPerm[j % 16]];
            total++; if (gotQ[j] !== exp) begin bad++; $display("FAIL b2b_byte%0d got=%02h want=%02h", j, gotQ[j], exp); end
            if (gotLastQ[j] !== ((j % 16) == 15)) lastErr++;
        end
        total++; if (lastErr != 0) begin bad++; $display("FAIL b2b_out_last got=%0d_wrong want=0_wrong", lastErr); end
    endtask

    task automatic test_frame_err;
        int sent;
        int acceptCyc;
        int errCyc;
        int errCnt;
        int outSeen;
        logic [7:0] exp;
        sent = 0;
        acceptCyc = -10;
        errCyc = -1;
        errCnt = 0;
        outSeen = 0;
        outReady = 1'b1;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clk);
            if (frameErr) begin
                errCnt++;
                if (errCyc < 0) errCyc = cyc;
            end
            if (outValid) outSeen++;
            if (sent < 5) begin
                inValid = 1'b1;
                inData = 8'hA0 + 8'(sent);
                inLast = (sent == 4);
                if (inReady) begin
                    if (sent == 4) acceptCyc = cyc;
                    sent++;
                end
            end else begin
                inValid = 1'b0;
                inLast = 1'b0;
            end
        end
        total++; if (errCnt != 1) begin bad++; $display("FAIL ferr_pulse_width got=%0d want=1", errCnt); end
        total++; if (errCyc != acceptCyc + 1) begin bad++; $display("FAIL ferr_pulse_time got=%0d want=%0d", errCyc, acceptCyc + 1); end
        total++; if (outSeen != 0) begin bad++; $display("FAIL ferr_no_output got=%0d want=0", outSeen); end
        srcQ.delete();
        lastQ.delete();
        load_block(8'hB0);
        drive_collect(16, 0, 16, 80);
        total++; if (timedOut || gotQ.size() != 16) begin bad++; $display("FAIL ferr_clean_count got=%0d want=16", gotQ.size()); end
        for (int j = 0; j < 16 && j < gotQ.size(); j++) begin
            exp = srcQ[invPerm[j]];
            total++; if (gotQ[j] !== exp) begin bad++; $display("FAIL ferr_clean_byte%0d got=%02h want=%02h", j, gotQ[j], exp); end
        end
        total++; if (fErrCnt != 0) begin bad++; $display("FAIL ferr_clean_no_err got=%0d want=0", fErrCnt); end
    endtask

    task automatic test_random_stall;
        logic [7:0] exp;
        srcQ.delete();
        lastQ.delete();
        load_block(8'hC0);
        load_block(8'hD7);
        drive_collect(32, 1, 32, 400);
        total++; if (timedOut || gotQ.size() != 32) begin bad++; $display("FAIL rand_count got=%0d want=32", gotQ.size()); end
        for (int j = 0; j < 32 && j < gotQ.size(); j++) begin
            exp = srcQ[(j / 16) * 16 + invPerm[j % 16]];
            total++; if (gotQ[j] !== exp) begin bad++; $display("FAIL rand_byte%0d got=%02h want=%02h", j, gotQ[j], exp); end
        end
        total++; if (stallBad != 0) begin bad++; $display("FAIL rand_stall_stable got=%0d_changes want=0_changes", stallBad); end
        total++; if (stallCnt == 0) begin bad++; $display("FAIL rand_stall_seen got=0 want=nonzero"); end
    endtask

    task automatic test_mid_reset;
        int wrote;
        int readN;
        logic [7:0] exp;
        srcQ.delete();
        lastQ.delete();
        load_block(8'h10);
        drive_collect(16, 2, 0, 60);
        wrote = 0;
        readN = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            outReady = (i < 4);
            if (outValid && outReady) readN++;
            inValid = 1'b1;
            inData = 8'h30 + 8'(i);
            inLast = 1'b0;
            if (inReady) wrote++;
        end
        @(posedge clk);
        inValid = 1'b0;
        outReady = 1'b0;
        total++; if (wrote != 9 || readN != 4) begin bad++; $display("FAIL mrst_setup got=%0d/%0d want=9/4", wrote, readN); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (inReady !== 1'b1) begin bad++; $display("FAIL mrst_in_ready got=%0b want=1", inReady); end
        total++; if (outValid !== 1'b0) begin bad++; $display("FAIL mrst_out_valid got=%0b want=0", outValid); end
        total++; if (outData !== 8'h00) begin bad++; $display("FAIL mrst_out_data got=%02h want=00", outData); end
        total++; if (outLast !== 1'b0) begin bad++; $display("FAIL mrst_out_last got=%0b want=0", outLast); end
        total++; if (frameErr !== 1'b0) begin bad++; $display("FAIL mrst_frame_err got=%0b want=0", frameErr); end
        @(negedge clk);
        rst_n = 1'b1;
        srcQ.delete();
        lastQ.delete();
        load_block(8'h70);
        drive_collect(16, 0, 16, 80);
        total++; if (timedOut || gotQ.size() != 16) begin bad++; $display("FAIL mrst_post_count got=%0d want=16", gotQ.size()); end
        for (int j = 0; j < 16 && j < gotQ.size(); j++) begin
            exp = srcQ[invPerm[j]];
            total++; if (gotQ[j] !== exp) begin bad++; $display("FAIL mrst_post_byte%0d got=%02h want=%02h", j, gotQ[j], exp); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_loopback();
        test_back_to_back();
        test_frame_err();
        test_random_stall();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inv_shift_row_stream.md
# inv_shift_row_stream

Byte-serial AES InvShiftRows unit for the decryption path. Accepts a 128-bit state as 16 bytes over a valid/ready stream, buffers it in a two-bank ping-pong store, and emits the inverse-row-shifted state as 16 bytes over a second valid/ready stream. One bank fills while the other drains, sustaining one byte per cycle. The same block built with `INVERSE=0` gives the forward ShiftRows permutation for loopback testing.

## Interface
- `INVERSE`, default 1: 1 selects the InvShiftRows permutation; 0 selects the forward ShiftRows permutation.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  input state byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_last`  in  1  marks byte 15 of a block.
- `in_ready`  out  1  the block can accept a byte this cycle.
- `out_data`  out  8  output state byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_last`  out  1  marks output byte 15.
- `out_ready`  in  1  downstream accepts the byte this cycle.
- `frame_err`  out  1  one-cycle pulse on a framing violation.

## Operation
- Byte index k = 4*c + r (c = column, r = row). Byte 0 is state bits [127:120]; byte 15 is bits [7:0]. Input and output streams both run in order k = 0..15.
- Inverse (`INVERSE=1`): output byte (c,r) = input byte ((c−r) mod 4, r).
  - Source index for output k = 0..15: 0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3.
- Forward (`INVERSE=0`): output byte (c,r) = input byte ((c+r) mod 4, r).
- Write side:
  - Registers: `wr_bank` (1 bit) and `wr_cnt` (4 bits).
  - A byte is accepted when `in_valid && in_ready`. It is written to bank[`wr_bank`][`wr_cnt`], and `wr_cnt` increments.
  - `in_ready` = !full[`wr_bank`].
- Block completion: the 16th byte is accepted with `in_last`=1. On that edge: full[`wr_bank`] is set, `wr_bank` toggles, and `wr_cnt` wraps to 0.
- Framing error: `in_last`=1 at `wr_cnt`≠15, or `in_last`=0 at `wr_cnt`=15.
  - The partial block is discarded: `wr_cnt` returns to 0, `wr_bank` is unchanged, and the full flag is not set.
  - `frame_err` pulses high for the next cycle.
- Read side:
  - Registers: `rd_bank` and `rd_cnt`.
  - `out_valid` = full[`rd_bank`].
  - `out_data` = bank[`rd_bank`][src(`rd_cnt`)], where src() is a combinational mux off the registers.
  - `out_last` = `out_valid` && `rd_cnt`==15.
  - A byte transfers when `out_valid && out_ready`, and `rd_cnt` increments.
  - On the transfer at 15: full[`rd_bank`] clears, `rd_bank` toggles, and `rd_cnt` wraps to 0.
- Simultaneous events: the set of full[i] (write completion) and the clear of full[j] (read completion) in the same cycle always target different banks, and both take effect.
- The full flags are the only shared state. The write side never writes into a full bank.
- Reset (asynchronous, at any time, including mid-block): all counters and bank pointers go to 0, full flags clear, and bank contents clear to 0. Any in-flight partial block is lost.
- Output values during reset: `in_ready`=1, `out_valid`=0, `out_data`=0x00, `out_last`=0, `frame_err`=0.

## Timing
- Latency: 16th input byte accepted at edge t → `out_valid`=1 with output byte 0 in the cycle after t.
- Throughput: one byte per cycle sustained when `in_valid` and `out_ready` are held high. Two banks fully hide the drain.
- Backpressure:
  - If both banks are full, `in_ready`=0 until the read side completes a bank.
  - `in_ready` rises in the cycle after the read side accepts output byte 15.
- `out_data` and `out_last` hold stable while `out_valid && !out_ready`.
- `in_ready` depends only on registers, with no combinational path from `out_ready`.

## Structure
- Shared AES package holds:
  - state byte-index helpers (k ↔ (c,r));
  - `AES_NB`=4 and `AES_STATE_BYTES`=16;
  - the two 16-entry 4-bit source-index constant arrays (inverse and forward).
- One natural sub-module: `shift_row_index`, a combinational map rd_cnt → src selected by `INVERSE`. It is reusable by a future byte-serial SubBytes/MixColumns pipeline.

## Test plan
- Bytes 0x00..0x0F with `in_last` on byte 15, `out_ready`=1 → output 0x00,0x0D,0x0A,0x07,0x04,0x01,0x0E,0x0B,0x08,0x05,0x02,0x0F,0x0C,0x09,0x06,0x03. `out_last` is high on 0x03; the first output appears one cycle after input byte 15.
- Loopback: `INVERSE=0` instance feeds `INVERSE=1` instance. FIPS-197 round-1 state 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08 → identical 16 bytes out.
- Three back-to-back blocks with `out_ready`=0 → `in_ready` falls after 32 accepted bytes. Raising `out_ready` drains 48 bytes in order; `in_ready` returns the cycle after the first block's byte 15 is read.
- `in_last`=1 on the 5th byte → `frame_err` single-cycle pulse, nothing emitted. The next 16 clean bytes produce one correct block.
- Random `out_ready` toggling → `out_data` is stable while stalled and no byte is lost or duplicated.
- `rst_n` asserted after 9 bytes written and 4 bytes read → all outputs at reset values immediately. The post-reset block output is correct, with no residue from the earlier data.
